// File: rtl/ps2_packet_receiver_if.sv
// PS/2 receive-path bundle: line inputs, enable, and byte/packet results.
// The receiver sits on the slave side; the consumer or a driver sits on the master side.
interface ps2_packet_receiver_if;
    logic        rx_en;
    logic        ps2_clk_in;
    logic        ps2_dat_in;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic [23:0] packet;
    logic        packet_valid;
    logic        parity_err;
    logic        frame_err;
    logic        busy;

    modport master (
        output rx_en, ps2_clk_in, ps2_dat_in,
        input  rx_byte, rx_byte_valid, packet, packet_valid, parity_err, frame_err, busy
    );

    modport slave (
        input  rx_en, ps2_clk_in, ps2_dat_in,
        output rx_byte, rx_byte_valid, packet, packet_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/ps2_packet_receiver.sv
// PS/2 mouse receive path: synchronizes the raw clock/data lines, deserializes
// 11-bit device-to-host frames into bytes, and assembles aligned 3-byte packets.
// Line driving and movement decoding live downstream in mouse_decoder.
module ps2_packet_receiver #(
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic                 slow_clock,
    input  logic                 reset,
    ps2_packet_receiver_if.slave bus_if
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    // The counter is compared before it increments, so the frame is abandoned
    // on the edge where it would reach TIMEOUT_CYCLES-1.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // A PS/2 frame carries odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic          clk_s1_q, clk_s2_q, clk_prev_q;
    logic          dat_s1_q, dat_s2_q;
    logic          fall_s;
    logic          dat_s;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   stage_q, stage_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_byte_valid_q, rx_byte_valid_d;
    logic [23:0]   packet_q, packet_d;
    logic          packet_valid_q, packet_valid_d;
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q, frame_err_d;
    logic          busy_q;

    // Two-flop synchronizers plus the delayed clock sample used for fall detection; idle lines are high.
    always_ff @(posedge slow_clock or negedge reset) begin
        if (!reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= bus_if.ps2_clk_in;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= bus_if.ps2_dat_in;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall_s = clk_prev_q & ~clk_s2_q;
    assign dat_s  = dat_s2_q;

    // Frame FSM, inter-edge timeout, byte outcome and packet assembly.
    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        shreg_d         = shreg_q;
        par_d           = par_q;
        tmo_d           = tmo_q;
        idx_d           = idx_q;
        stage_d         = stage_q;
        rx_byte_d       = rx_byte_q;
        packet_d        = packet_q;
        rx_byte_valid_d = 1'b0;
        packet_valid_d  = 1'b0;
        parity_err_d    = 1'b0;
        frame_err_d     = 1'b0;

        if (!bus_if.rx_en) begin
            // Host owns the lines: drop any partial frame and packet silently.
            state_d   = S_IDLE;
            bit_cnt_d = 3'd0;
            tmo_d     = {TW{1'b0}};
            idx_d     = 2'd0;
        end else if (fall_s) begin
            tmo_d = {TW{1'b0}};
            case (state_q)
                S_IDLE: begin
                    if (!dat_s) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DATA: begin
                    shreg_d   = {dat_s, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_PARITY: begin
                    par_d   = dat_s;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!dat_s) begin
                        frame_err_d = 1'b1;
                        idx_d       = 2'd0;
                    end else if (!odd_parity_ok(shreg_q, par_q)) begin
                        parity_err_d = 1'b1;
                        idx_d        = 2'd0;
                    end else begin
                        rx_byte_d       = shreg_q;
                        rx_byte_valid_d = 1'b1;
                        case (idx_q)
                            2'd0: begin
                                // Only a byte with the always-one status bit can open a packet.
                                if (shreg_q[3]) begin
                                    stage_d[7:0] = shreg_q;
                                    idx_d        = 2'd1;
                                end else begin
                                    idx_d = 2'd0;
                                end
                            end
                            2'd1: begin
                                stage_d[15:8] = shreg_q;
                                idx_d         = 2'd2;
                            end
                            2'd2: begin
                                packet_d       = {shreg_q, stage_q};
                                packet_valid_d = 1'b1;
                                idx_d          = 2'd0;
                            end
                            default: begin
                                idx_d = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else if (state_q != S_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d     = S_IDLE;
                frame_err_d = 1'b1;
                idx_d       = 2'd0;
                tmo_d       = {TW{1'b0}};
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = {TW{1'b0}};
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge slow_clock or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            bit_cnt_q       <= 3'd0;
            shreg_q         <= 8'd0;
            par_q           <= 1'b0;
            tmo_q           <= {TW{1'b0}};
            idx_q           <= 2'd0;
            stage_q         <= 16'd0;
            rx_byte_q       <= 8'd0;
            rx_byte_valid_q <= 1'b0;
            packet_q        <= 24'd0;
            packet_valid_q  <= 1'b0;
            parity_err_q    <= 1'b0;
            frame_err_q     <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            shreg_q         <= shreg_d;
            par_q           <= par_d;
            tmo_q           <= tmo_d;
            idx_q           <= idx_d;
            stage_q         <= stage_d;
            rx_byte_q       <= rx_byte_d;
            rx_byte_valid_q <= rx_byte_valid_d;
            packet_q        <= packet_d;
            packet_valid_q  <= packet_valid_d;
            parity_err_q    <= parity_err_d;
            frame_err_q     <= frame_err_d;
            busy_q          <= (state_d != S_IDLE);
        end
    end

    assign bus_if.rx_byte       = rx_byte_q;
    assign bus_if.rx_byte_valid = rx_byte_valid_q;
    assign bus_if.packet        = packet_q;
    assign bus_if.packet_valid  = packet_valid_q;
    assign bus_if.parity_err    = parity_err_q;
    assign bus_if.frame_err     = frame_err_q;
    assign bus_if.busy          = busy_q;
endmodule

// File: tb/tb_ps2_packet_receiver.sv
// Bench for ps2_packet_receiver: directed scenarios with literal expectations plus
// randomized frames checked against a byte/packet-level reference model.
module tb_ps2_packet_receiver;
    localparam int T = 200;

    logic slow_clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   last_fall = 0;

    ps2_packet_receiver_if bus ();

    ps2_packet_receiver #(.TIMEOUT_CYCLES(T)) dut (
        .slow_clock (slow_clock),
        .reset      (reset),
        .bus_if     (bus)
    );

    always #5 slow_clock = ~slow_clock;

    always @(posedge slow_clock) cyc <= cyc + 1;

    // Observed pulses, sampled on the falling edge.
    logic [7:0]  got_b[$];
    int          got_b_cyc[$];
    logic [23:0] got_p[$];
    int          got_p_cyc[$];
    int          got_perr = 0;
    int          got_ferr = 0;
    int          last_ferr_cyc = 0;

    always @(negedge slow_clock) begin
        if (bus.rx_byte_valid) begin got_b.push_back(bus.rx_byte); got_b_cyc.push_back(cyc); end
        if (bus.packet_valid) begin got_p.push_back(bus.packet); got_p_cyc.push_back(cyc); end
        if (bus.parity_err) got_perr++;
        if (bus.frame_err) begin got_ferr++; last_ferr_cyc = cyc; end
        if (bus.rx_byte_valid | bus.parity_err | bus.frame_err | bus.packet_valid) begin
            total++;
            if ($countones({bus.rx_byte_valid, bus.parity_err, bus.frame_err}) > 1 ||
                (bus.packet_valid && !bus.rx_byte_valid)) begin
                bad++;
                $display("FAIL pulse_exclusive at cyc %0d: valid=%b perr=%b ferr=%b pkt=%b",
                         cyc, bus.rx_byte_valid, bus.parity_err, bus.frame_err, bus.packet_valid);
            end
        end
    end

    // Reference model: frames reduce to outcomes, good bytes feed a 3-slot packet buffer.
    logic [7:0]  exp_b[$];
    logic [23:0] exp_p[$];
    int          exp_perr = 0;
    int          exp_ferr = 0;
    int          m_idx = 0;
    logic [7:0]  m_buf [3];
    logic [7:0]  m_last_byte = 8'h00;
    logic [23:0] m_last_pkt = 24'h0;

    function automatic logic odd_par(input logic [7:0] b);
        return ($countones(b) % 2) == 0;
    endfunction

    task automatic model_frame(input logic [7:0] b, input logic par, input logic stop);
        if (!stop) begin
            exp_ferr++;
            m_idx = 0;
        end else if ((($countones(b) + int'(par)) % 2) == 0) begin
            exp_perr++;
            m_idx = 0;
        end else begin
            exp_b.push_back(b);
            m_last_byte = b;
            if (!(m_idx == 0 && b[3] == 1'b0)) begin
                m_buf[m_idx] = b;
                m_idx++;
                if (m_idx == 3) begin
                    m_last_pkt = {m_buf[2], m_buf[1], m_buf[0]};
                    exp_p.push_back(m_last_pkt);
                    m_idx = 0;
                end
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge slow_clock); #1; end
    endtask

    task automatic send_bit(input logic b, input int hp);
        bus.ps2_dat_in = b;
        tick(hp);
        bus.ps2_clk_in = 1'b0;
        last_fall = cyc;
        tick(hp);
        bus.ps2_clk_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int hp);
        send_bit(1'b0, hp);
        for (int i = 0; i < 8; i++) send_bit(b[i], hp);
        send_bit(par, hp);
        send_bit(stop, hp);
        bus.ps2_dat_in = 1'b1;
        if (bus.rx_en) model_frame(b, par, stop);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, odd_par(b), 1'b1, 4);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
        got_b.delete(); got_b_cyc.delete(); got_p.delete(); got_p_cyc.delete();
        got_perr = 0; got_ferr = 0;
        exp_b.delete(); exp_p.delete(); exp_perr = 0; exp_ferr = 0;
        m_idx = 0; m_last_byte = 8'h00; m_last_pkt = 24'h0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        total++; if (bus.rx_byte !== 8'h00 || bus.packet !== 24'h0) begin bad++;
            $display("FAIL reset_data got rx_byte=%h packet=%h want 00/000000", bus.rx_byte, bus.packet); end
        total++; if ({bus.rx_byte_valid, bus.packet_valid, bus.parity_err, bus.frame_err, bus.busy} !== 5'b0) begin bad++;
            $display("FAIL reset_flags got %b want 00000",
                     {bus.rx_byte_valid, bus.packet_valid, bus.parity_err, bus.frame_err, bus.busy}); end
        do_reset();
    endtask

    task automatic test_single_byte();
        do_reset();
        send_frame(8'h08, 1'b0, 1'b1, 4);
        tick(4);
        total++; if (got_b.size() != 1) begin bad++;
            $display("FAIL single_count got %0d want 1", got_b.size()); end
        else begin
            total++; if (got_b[0] !== 8'h08) begin bad++;
                $display("FAIL single_byte got %h want 08", got_b[0]); end
            total++; if (got_b_cyc[0] != last_fall + 3) begin bad++;
                $display("FAIL single_latency got %0d want %0d", got_b_cyc[0], last_fall + 3); end
        end
        total++; if (got_perr + got_ferr != 0) begin bad++;
            $display("FAIL single_errs got %0d want 0", got_perr + got_ferr); end
        total++; if (bus.rx_byte !== 8'h08 || bus.busy !== 1'b0) begin bad++;
            $display("FAIL single_hold got rx_byte=%h busy=%b want 08/0", bus.rx_byte, bus.busy); end
    endtask

    task automatic test_full_packet();
        do_reset();
        send_good(8'h09); send_good(8'h05); send_good(8'hFB);
        tick(4);
        total++; if (got_p.size() != 1 || got_b.size() != 3) begin bad++;
            $display("FAIL packet_count got pkts=%0d bytes=%0d want 1/3", got_p.size(), got_b.size()); end
        else begin
            total++; if (got_p[0] !== 24'hFB0509) begin bad++;
                $display("FAIL packet_value got %h want fb0509", got_p[0]); end
            total++; if (got_p_cyc[0] != got_b_cyc[2]) begin bad++;
                $display("FAIL packet_align got %0d want %0d", got_p_cyc[0], got_b_cyc[2]); end
        end
        total++; if (bus.packet !== 24'hFB0509) begin bad++;
            $display("FAIL packet_hold got %h want fb0509", bus.packet); end
    endtask

    task automatic test_parity_recovery();
        do_reset();
        send_good(8'h08);
        send_frame(8'h55, 1'b0, 1'b1, 4);
        tick(4);
        total++; if (got_perr != 1 || got_b.size() != 1) begin bad++;
            $display("FAIL parity_pulse got perr=%0d bytes=%0d want 1/1", got_perr, got_b.size()); end
        total++; if (bus.rx_byte !== 8'h08) begin bad++;
            $display("FAIL parity_rx_hold got %h want 08", bus.rx_byte); end
        send_good(8'h08); send_good(8'h01); send_good(8'h02);
        tick(4);
        total++; if (got_p.size() != 1 || bus.packet !== 24'h020108) begin bad++;
            $display("FAIL parity_recover got pkts=%0d packet=%h want 1/020108", got_p.size(), bus.packet); end
    endtask

    task automatic test_misalign();
        do_reset();
        send_good(8'h00); send_good(8'h08); send_good(8'h01); send_good(8'h02);
        tick(4);
        total++; if (got_b.size() != 4 || got_p.size() != 1) begin bad++;
            $display("FAIL misalign_count got bytes=%0d pkts=%0d want 4/1", got_b.size(), got_p.size()); end
        else begin
            total++; if (got_p[0] !== 24'h020108 || got_p_cyc[0] != got_b_cyc[3]) begin bad++;
                $display("FAIL misalign_packet got %h @%0d want 020108 @%0d", got_p[0], got_p_cyc[0], got_b_cyc[3]); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send_bit(1'b0, 4);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 4);
        bus.ps2_dat_in = 1'b1;
        total++; if (bus.busy !== 1'b1) begin bad++;
            $display("FAIL timeout_busy_mid got %b want 1", bus.busy); end
        tick(T + 10);
        total++; if (got_ferr != 1) begin bad++;
            $display("FAIL timeout_pulse got %0d want 1", got_ferr); end
        total++; if (last_ferr_cyc != last_fall + 3 + T - 1) begin bad++;
            $display("FAIL timeout_latency got %0d want %0d", last_ferr_cyc, last_fall + 3 + T - 1); end
        total++; if (bus.busy !== 1'b0) begin bad++;
            $display("FAIL timeout_busy got %b want 0", bus.busy); end
        send_good(8'h3C);
        tick(4);
        total++; if (got_b.size() != 1 || bus.rx_byte !== 8'h3C) begin bad++;
            $display("FAIL timeout_next got count=%0d rx_byte=%h want 1/3c", got_b.size(), bus.rx_byte); end
    endtask

    task automatic test_rx_en_and_reset();
        do_reset();
        send_good(8'h18); send_good(8'hFF);
        bus.rx_en = 1'b0;
        m_idx = 0;
        tick(2);
        send_good(8'h08);
        tick(T + 10);
        total++; if (got_p.size() != 0 || got_b.size() != 2 || got_ferr != 0) begin bad++;
            $display("FAIL rx_en_quiet got pkts=%0d bytes=%0d ferr=%0d want 0/2/0", got_p.size(), got_b.size(), got_ferr); end
        total++; if (bus.rx_byte !== 8'hFF || bus.busy !== 1'b0) begin bad++;
            $display("FAIL rx_en_hold got rx_byte=%h busy=%b want ff/0", bus.rx_byte, bus.busy); end
        bus.rx_en = 1'b1;
        tick(2);
        send_good(8'h18); send_good(8'hFF); send_good(8'h00);
        tick(4);
        total++; if (got_p.size() != 1 || bus.packet !== 24'h00FF18) begin bad++;
            $display("FAIL rx_en_packet got pkts=%0d packet=%h want 1/00ff18", got_p.size(), bus.packet); end
        send_bit(1'b0, 4); send_bit(1'b1, 4); send_bit(1'b0, 4);
        total++; if (bus.busy !== 1'b1) begin bad++;
            $display("FAIL midframe_busy got %b want 1", bus.busy); end
        #2 reset = 1'b0;
        #1;
        total++; if (bus.rx_byte !== 8'h00 || bus.packet !== 24'h0 || bus.busy !== 1'b0) begin bad++;
            $display("FAIL async_reset got rx_byte=%h packet=%h busy=%b want 00/000000/0", bus.rx_byte, bus.packet, bus.busy); end
        bus.ps2_dat_in = 1'b1;
        do_reset();
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         r;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 1) == 1) b[3] = 1'b1;
            r = $urandom_range(0, 15);
            send_frame(b, odd_par(b) ^ (r == 1 || r == 2), (r != 0), $urandom_range(3, 5));
            tick($urandom_range(0, 6));
        end
        tick(8);
        total++; if (got_b.size() != exp_b.size()) begin bad++;
            $display("FAIL random_byte_count got %0d want %0d", got_b.size(), exp_b.size()); end
        else for (int i = 0; i < exp_b.size(); i++) begin
            total++; if (got_b[i] !== exp_b[i]) begin bad++;
                $display("FAIL random_byte[%0d] got %h want %h", i, got_b[i], exp_b[i]); end
        end
        total++; if (got_p.size() != exp_p.size()) begin bad++;
            $display("FAIL random_pkt_count got %0d want %0d", got_p.size(), exp_p.size()); end
        else for (int i = 0; i < exp_p.size(); i++) begin
            total++; if (got_p[i] !== exp_p[i]) begin bad++;
                $display("FAIL random_pkt[%0d] got %h want %h", i, got_p[i], exp_p[i]); end
        end
        total++; if (got_perr != exp_perr || got_ferr != exp_ferr) begin bad++;
            $display("FAIL random_errs got perr=%0d ferr=%0d want %0d/%0d", got_perr, got_ferr, exp_perr, exp_ferr); end
        total++; if (bus.rx_byte !== m_last_byte || bus.packet !== m_last_pkt) begin bad++;
            $display("FAIL random_outputs got %h/%h want %h/%h", bus.rx_byte, bus.packet, m_last_byte, m_last_pkt); end
    endtask

    initial begin
        reset = 1'b0;
        bus.rx_en = 1'b1;
        bus.ps2_clk_in = 1'b1;
        bus.ps2_dat_in = 1'b1;
        test_reset();
        test_single_byte();
        test_full_packet();
        test_parity_recovery();
        test_misalign();
        test_timeout();
        test_rx_en_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
